uart_tx_fifo: RTL

//  Buffered UART transmitter: byte FIFO in front of an 8N1 serializer. Lets the cipher

---
 rtl/uart_pkg.sv | 7 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and serializer state encoding.
package uart_pkg;
    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/count flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q, count_d;
    logic full_q, empty_q, do_push, do_pop;
    // A push into a full FIFO is dropped even when a pop happens the same cycle.
    always_comb begin
        do_push = push_i && !full_q;
        do_pop = pop_i && !empty_q;
        count_d = (do_push && !do_pop) ? count_q + 1'b1 :
                  (!do_push && do_pop) ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q <= count_d;
            full_q <= count_d == (AW+1)'(DEPTH);
            empty_q <= count_d == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
    assign data_o = mem_q[rd_ptr_q];
    assign full_o = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serializer with registered line outputs.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W = $clog2(FIFO_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    output logic            tx,
    output logic            active,
    output logic            done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, head;
    logic pop, last, tx_q, active_q, done_q, overflow_q;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(ADDR_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(wr_en),
        .pop_i(pop),
        .data_i(wr_data),
        .data_o(head),
        .full_o(full),
        .empty_o(empty),
        .count_o(count)
    );
    assign last = baud_q == BW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        pop = 1'b0;
        baud_d = (state_q == IDLE || last) ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    shift_d = head;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    bit_d = '0;
                end
            end
            DATA: begin
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    state_d = (bit_q == 3'(DATA_BITS - 1)) ? STOP : DATA;
                end
            end
            STOP: begin
                // Back-to-back frames: reload straight into START with no idle bit.
                if (last) begin
                    pop = !empty;
                    shift_d = empty ? shift_q : head;
                    state_d = empty ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            tx_q <= 1'b1;
            active_q <= 1'b0;
            done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            tx_q <= (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[bit_q] : 1'b1;
            active_q <= state_q != IDLE;
            done_q <= state_q == STOP && last;
            overflow_q <= overflow_q | (wr_en & full);
        end
    end
    assign tx = tx_q;
    assign active = active_q;
    assign done = done_q;
    assign overflow = overflow_q;
endmodule
